icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the inst1 request port of the memory interface.
- Acts as the requester on that port: raises valid/addr and holds them until ready.
- Serves fetch hits combinationally from internal storage.
- On a miss, refills a whole line by issuing sequential word requests.
- Aborts any refill and drops the partially filled line on rob_clear.

Parameters:
- INDEX_BITS, 5: log2 of line count (32 lines).
- WORD_BITS, 2: log2 of 32-bit words per line (4 words = 16 B).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rdy_in  input  1  ready; all state frozen while low.
- rob_clear  input  1  pipeline flush.
- fetch_valid  input  1  fetcher requests the instruction at fetch_addr.
- fetch_addr  input  32  byte address; bits [1:0] ignored.
- fetch_ready  output  1  fetch_inst is valid this cycle.
- fetch_inst  output  32  instruction word.
- mem_valid  output  1  word request to the memory interface (inst1_valid).
- mem_addr  output  32  word address of the request (inst1_addr).
- mem_ready  input  1  requested word returned (inst1_ready).
- mem_result  input  32  returned word (inst1_result).

Behaviour:
- Address split:
  - OFF = 2 + WORD_BITS.
  - index = fetch_addr[OFF+INDEX_BITS-1:OFF].
  - word = fetch_addr[OFF-1:2].
  - tag = fetch_addr[31:OFF+INDEX_BITS].
- Storage per line: valid bit, tag, 2^WORD_BITS data words.
- Reset (async): all valid bits 0; state IDLE; refill counter 0; fetch_ready 0; mem_valid 0; mem_addr 0. Data array is not cleared.
- States: IDLE, REFILL.
- IDLE:
  - hit = fetch_valid && valid[index] && tag match.
  - On a hit: fetch_ready=1 and fetch_inst=data[index][word], same cycle (0-cycle hit latency).
  - On a miss, when rdy_in && !rob_clear: latch line base = {fetch_addr[31:OFF], OFF'b0}, clear valid[index], counter=0, go to REFILL.
- REFILL:
  - mem_valid = !rob_clear (combinational).
  - mem_addr = base + 4*counter; held stable until mem_ready.
  - fetch_ready = 0 throughout REFILL, even for addresses that would hit in other lines.
  - On mem_ready && rdy_in: write mem_result to data[line][counter], counter++.
  - On the last word (counter == 2^WORD_BITS-1), additionally set valid and tag, then go to IDLE.
  - Miss-to-deliver latency = 2^WORD_BITS memory transactions + 1 cycle; the re-presented fetch hits in the first IDLE cycle.
  - A fetch_addr change during REFILL does not retarget the refill. The latched line completes, then IDLE re-evaluates.
- rob_clear (priority over everything except reset):
  - fetch_ready=0 and mem_valid=0 in the same cycle.
  - At the edge: REFILL → IDLE, the line stays invalid, counter=0.
  - A coincident mem_ready is discarded.
- rdy_in low: no state or array update. Outputs remain a function of the held state. mem_ready is ignored.
- mem_ready outside REFILL: ignored.
- Reset mid-refill: returns to IDLE with all lines invalid; no further mem_valid.
- Boundary cases:
  - Conflict miss evicts the resident line unconditionally.
  - Wrap at 0xFFFFFFF0 needs no special case; the line is contained within its aligned block.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined: adds output ports perf_hit [31:0] and perf_miss [31:0].
  - perf_hit counts cycles with a hit in IDLE, with rdy_in && !rob_clear.
  - perf_miss counts IDLE→REFILL transitions.
  - Both reset to 0 asynchronously and wrap modulo 2^32.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Shared package:
  - State encoding localparams IDLE=1'b0, REFILL=1'b1.
  - OFF / TAG_BITS derivation.
  - Instruction width constant, 32.
- Sub-module icache_array:
  - Contents: valid/tag/data storage.
  - Ports: async-reset valid clear, combinational read by index, a word-write port, and a line-validate port.
- icache_fetch holds only the FSM, counter and handshake.

Test Plan (INDEX_BITS=5, WORD_BITS=2):
- Cold miss at 0x100:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C; mem_result 0x00000013, 0x00100093, 0x00200113, 0x00300193.
  - One cycle after the 4th mem_ready: fetch_ready=1 with fetch_inst=0x00000013.
- Hit at 0x108 after the fill: fetch_ready=1 in the same cycle with 0x00200113; mem_valid stays 0.
- Conflict at 0x300 (index 0x10): refill reads 0x300..0x30C. A subsequent fetch of 0x100 misses and refetches from 0x100.
- rob_clear in the cycle of the 2nd mem_ready:
  - mem_valid=0 in that cycle; next state is IDLE.
  - Fetch of 0x104 misses and the refill restarts at mem_addr 0x100.
- rdy_in low for 3 cycles mid-refill, including a pulsed mem_ready: counter and mem_addr hold, and the pulse is ignored. The refill resumes and completes with exactly 4 accepted words.
- ICACHE_PERF_EN: cold miss, then 3 hit cycles, then a conflict miss → perf_miss=2, perf_hit=3. Async rst_in mid-run zeroes both immediately.

Source files
------------

// File: rtl/icache_fetch_pkg.sv
// Shared constants, state encoding and address-split helpers for the instruction cache.
package icache_fetch_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Byte offset of the line index: two byte-select bits plus the word-select bits.
    function automatic int off_bits(input int word_bits);
        return 2 + word_bits;
    endfunction

    function automatic int tag_bits(input int index_bits, input int word_bits);
        return ADDR_WIDTH - off_bits(word_bits) - index_bits;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Valid bits reset asynchronously; tags and data are never cleared.
module icache_array
    import icache_fetch_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int WORD_BITS  = 2,
    parameter int TAG_W      = tag_bits(INDEX_BITS, WORD_BITS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [INST_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [INST_WIDTH-1:0] wr_data,
    input  logic                  set_en,
    input  logic [TAG_W-1:0]      set_tag,
    input  logic                  clr_en,
    input  logic [INDEX_BITS-1:0] clr_index
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [INST_WIDTH-1:0] data_q [LINES][WORDS];

    // set_en validates the line currently addressed by the write port.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_index] <= 1'b0;
            if (set_en) valid_q[wr_index]  <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en)  data_q[wr_index][wr_word] <= wr_data;
        if (set_en) tag_q[wr_index]           <= set_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: FSM, refill counter and memory handshake.
// Optional perf_hit/perf_miss counters are built when ICACHE_PERF_EN is defined.
module icache_fetch
    import icache_fetch_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int WORD_BITS  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic [INST_WIDTH-1:0] fetch_inst,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [INST_WIDTH-1:0] mem_result
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           perf_hit,
    output logic [31:0]           perf_miss
`endif
);

    localparam int OFF    = off_bits(WORD_BITS);
    localparam int TAG_W  = tag_bits(INDEX_BITS, WORD_BITS);
    localparam int LINE_W = ADDR_WIDTH - OFF;
    localparam logic [WORD_BITS-1:0] LAST_WORD = '1;

    state_t                  state_q, state_d;
    logic [WORD_BITS-1:0]    count_q, count_d;
    logic [LINE_W-1:0]       line_q, line_d;

    logic [INDEX_BITS-1:0]   fetch_index;
    logic [WORD_BITS-1:0]    fetch_word;
    logic [TAG_W-1:0]        fetch_tag;
    logic                    arr_valid;
    logic [TAG_W-1:0]        arr_tag;
    logic [INST_WIDTH-1:0]   arr_data;
    logic                    hit;
    logic                    start_refill;
    logic                    wr_en;
    logic                    set_en;
    logic                    unused_byte_bits;

    assign fetch_index      = fetch_addr[OFF+INDEX_BITS-1:OFF];
    assign fetch_word       = fetch_addr[OFF-1:2];
    assign fetch_tag        = fetch_addr[ADDR_WIDTH-1:OFF+INDEX_BITS];
    assign unused_byte_bits = ^fetch_addr[1:0];
    assign hit              = fetch_valid && arr_valid && (arr_tag == fetch_tag);

    // The word address walks the latched line; it only moves when a word is accepted.
    assign mem_addr   = {line_q, count_q, 2'b00};
    assign fetch_inst = arr_data;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rd_index   (fetch_index),
        .rd_word    (fetch_word),
        .rd_valid   (arr_valid),
        .rd_tag     (arr_tag),
        .rd_data    (arr_data),
        .wr_en      (wr_en),
        .wr_index   (line_q[INDEX_BITS-1:0]),
        .wr_word    (count_q),
        .wr_data    (mem_result),
        .set_en     (set_en),
        .set_tag    (line_q[LINE_W-1:INDEX_BITS]),
        .clr_en     (start_refill),
        .clr_index  (fetch_index)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            count_q <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            line_q  <= line_d;
        end
    end

    // rob_clear masks both outputs at once and, when rdy_in allows, aborts the refill;
    // with rdy_in low every next-state term keeps its current value.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        line_d       = line_q;
        fetch_ready  = 1'b0;
        mem_valid    = 1'b0;
        wr_en        = 1'b0;
        set_en       = 1'b0;
        start_refill = 1'b0;
        case (state_q)
            IDLE: begin
                fetch_ready = hit && !rob_clear;
                if (fetch_valid && !hit && rdy_in && !rob_clear) begin
                    start_refill = 1'b1;
                    line_d       = fetch_addr[ADDR_WIDTH-1:OFF];
                    count_d      = '0;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                mem_valid = !rob_clear;
                if (rdy_in) begin
                    if (rob_clear) begin
                        count_d = '0;
                        state_d = IDLE;
                    end else if (mem_ready) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                        if (count_q == LAST_WORD) begin
                            set_en  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else begin
            if (state_q == IDLE && hit && rdy_in && !rob_clear) perf_hit <= perf_hit + 32'd1;
            if (start_refill) perf_miss <= perf_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus randomized traffic
// compared every cycle against a block-residency model of the cache.
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_result = 32'h0;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int nAsserts = 0;
    int nFails   = 0;

    // Model: which 16-byte block each index holds, and the refill in flight.
    bit          mValid [32];
    logic [27:0] mBlock [32];
    bit          mRefilling;
    logic [27:0] mRefBlock;
    int          mCount;
    logic [31:0] mPerfHit;
    logic [31:0] mPerfMiss;

    always #5 clk_in = ~clk_in;

    icache_fetch dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_inst  (fetch_inst),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_result  (mem_result)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit    (perf_hit),
        .perf_miss   (perf_miss)
`endif
    );

    // Backing memory: the test-plan program at 0x100, a scrambled pattern elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h100: return 32'h00000013;
            32'h104: return 32'h00100093;
            32'h108: return 32'h00200113;
            32'h10C: return 32'h00300193;
            default: return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
        endcase
    endfunction

    function automatic bit modelHit();
        logic [4:0] idx;
        idx = fetch_addr[8:4];
        return !mRefilling && fetch_valid && mValid[idx] && (mBlock[idx] == fetch_addr[31:4]);
    endfunction

    function automatic logic [31:0] modelMemAddr();
        return {mRefBlock, 4'b0000} + 32'(4 * mCount);
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
        mRefilling = 1'b0;
        mCount     = 0;
        mPerfHit   = 32'h0;
        mPerfMiss  = 32'h0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic updateModel();
        bit h;
        if (rst_in) begin
            resetModel();
            return;
        end
        if (!rdy_in) return;
        h = modelHit();
        if (!mRefilling) begin
            if (h && !rob_clear) mPerfHit = mPerfHit + 32'd1;
            if (fetch_valid && !h && !rob_clear) begin
                mValid[fetch_addr[8:4]] = 1'b0;
                mRefilling = 1'b1;
                mRefBlock  = fetch_addr[31:4];
                mCount     = 0;
                mPerfMiss  = mPerfMiss + 32'd1;
            end
        end else if (rob_clear) begin
            mRefilling = 1'b0;
        end else if (mem_ready) begin
            mCount++;
            if (mCount == 4) begin
                mValid[mRefBlock[4:0]] = 1'b1;
                mBlock[mRefBlock[4:0]] = mRefBlock;
                mRefilling = 1'b0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the rising edge.
    always @(negedge clk_in) begin
        bit h;
        h = modelHit();
        checkOutput("fetch_ready", 32'(fetch_ready), 32'(h && !rob_clear));
        if (h && !rob_clear) checkOutput("fetch_inst", fetch_inst, memWord({fetch_addr[31:2], 2'b00}));
        checkOutput("mem_valid", 32'(mem_valid), 32'(mRefilling && !rob_clear));
        if (mRefilling) checkOutput("mem_addr", mem_addr, modelMemAddr());
`ifdef ICACHE_PERF_EN
        checkOutput("perf_hit", perf_hit, mPerfHit);
        checkOutput("perf_miss", perf_miss, mPerfMiss);
`endif
    end

    // Drive one cycle's inputs (called just after a rising edge) and wait for the falling edge.
    task automatic applyStimulus(input bit fv, input logic [31:0] fa, input bit rc, input bit rdy, input bit mr);
        fetch_valid = fv;
        fetch_addr  = fa;
        rob_clear   = rc;
        rdy_in      = rdy;
        mem_ready   = mr;
        mem_result  = mRefilling ? memWord(modelMemAddr()) : 32'hDEADBEEF;
        @(negedge clk_in);
    endtask

    task automatic finishCycle();
        @(posedge clk_in);
        updateModel();
        #1;
    endtask

    task automatic doReset();
        fetch_valid = 1'b0;
        rob_clear   = 1'b0;
        mem_ready   = 1'b0;
        rdy_in      = 1'b1;
        rst_in      = 1'b1;
        resetModel();
        #1;
        checkOutput("reset mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("reset fetch_ready", 32'(fetch_ready), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
`ifdef ICACHE_PERF_EN
        checkOutput("reset perf_hit", perf_hit, 32'h0);
        checkOutput("reset perf_miss", perf_miss, 32'h0);
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        finishCycle();
    endtask

    // Miss cycle followed by four accepted words with the expected word addresses.
    task automatic runMiss(input logic [31:0] a);
        applyStimulus(1'b1, a, 1'b0, 1'b1, 1'b0);
        checkOutput("miss fetch_ready", 32'(fetch_ready), 32'h0);
        finishCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, a, 1'b0, 1'b1, 1'b1);
            checkOutput("refill mem_addr", mem_addr, {a[31:4], 4'b0000} + 32'(4 * i));
            checkOutput("refill mem_valid", 32'(mem_valid), 32'h1);
            checkOutput("refill fetch_ready", 32'(fetch_ready), 32'h0);
            finishCycle();
        end
    endtask

    initial begin
        logic [27:0] pool [6];
        logic [27:0] blk;
        logic [31:0] ra;
        bit rdy, rc;

        doReset();

        runMiss(32'h100);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        checkOutput("cold deliver ready", 32'(fetch_ready), 32'h1);
        checkOutput("cold deliver inst", fetch_inst, 32'h00000013);
        finishCycle();

        applyStimulus(1'b1, 32'h108, 1'b0, 1'b1, 1'b0);
        checkOutput("hit 0x108 ready", 32'(fetch_ready), 32'h1);
        checkOutput("hit 0x108 inst", fetch_inst, 32'h00200113);
        checkOutput("hit 0x108 mem_valid", 32'(mem_valid), 32'h0);
        finishCycle();

        runMiss(32'h300);
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        checkOutput("conflict deliver ready", 32'(fetch_ready), 32'h1);
        finishCycle();

        // 0x100 was evicted; abort its refill on the second returned word.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        checkOutput("evicted 0x100 ready", 32'(fetch_ready), 32'h0);
        finishCycle();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
        checkOutput("refetch addr0", mem_addr, 32'h100);
        finishCycle();
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
        checkOutput("clear mem_valid", 32'(mem_valid), 32'h0);
        checkOutput("clear fetch_ready", 32'(fetch_ready), 32'h0);
        finishCycle();
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
        checkOutput("after clear idle", 32'(mem_valid), 32'h0);
        checkOutput("after clear miss", 32'(fetch_ready), 32'h0);
        finishCycle();
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b1);
        checkOutput("restart addr", mem_addr, 32'h100);
        checkOutput("restart valid", 32'(mem_valid), 32'h1);
        finishCycle();

        // rdy_in low for three cycles, with a mem_ready pulse that must be ignored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, i == 1);
            checkOutput("stall mem_addr", mem_addr, 32'h104);
            finishCycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b1);
            checkOutput("resume mem_addr", mem_addr, 32'h104 + 32'(4 * i));
            finishCycle();
        end
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
        checkOutput("resume deliver ready", 32'(fetch_ready), 32'h1);
        checkOutput("resume deliver inst", fetch_inst, 32'h00100093);
        finishCycle();

        // Reset in the middle of a refill.
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
        finishCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
        finishCycle();
        doReset();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        checkOutput("post-reset miss", 32'(fetch_ready), 32'h0);
        finishCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
            finishCycle();
        end

        runMiss(32'hFFFFFFF8);
        applyStimulus(1'b1, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0);
        checkOutput("top block ready", 32'(fetch_ready), 32'h1);
        finishCycle();

`ifdef ICACHE_PERF_EN
        doReset();
        runMiss(32'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
            finishCycle();
        end
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        finishCycle();
        checkOutput("perf_hit count", perf_hit, 32'd3);
        checkOutput("perf_miss count", perf_miss, 32'd2);
        doReset();
`endif

        // Randomized traffic over a few colliding blocks.
        pool[0] = 28'h0000010;
        pool[1] = 28'h0000030;
        pool[2] = 28'h0000011;
        pool[3] = 28'h0000050;
        pool[4] = 28'hFFFFFFF;
        pool[5] = 28'h0000031;
        ra = 32'h100;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                blk = pool[$urandom_range(0, 5)];
                ra  = {blk, 4'($urandom_range(0, 15))};
            end
            rdy = ($urandom_range(0, 9) != 0);
            rc  = rdy && ($urandom_range(0, 19) == 0);
            applyStimulus($urandom_range(0, 4) != 0, ra, rc, rdy, $urandom_range(0, 1) == 1);
            finishCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
